// File: rtl/fifo_pkg.sv
// Shared types and constants for the parametrised mailbox FIFO.
package fifo_pkg;

    // Status bundle presented on the FIFO outputs
    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
        logic ovf;
        logic udf;
    } fifo_stat_t;

    // Two-sample strobe history {older, newer} that marks a falling strobe
    localparam logic [1:0] STB_FALL = 2'b10;

    // Strobe interpretation modes
    localparam bit STB_EDGE_M  = 1'b1;
    localparam bit STB_PULSE_M = 1'b0;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// The read register is resettable so the head output starts at zero.
module fifo_mem #(
    parameter int DW = 8,
    parameter int AW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port; a same-address write returns the old word
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else     rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_sync_p.sv
// Single-clock mailbox FIFO with occupancy count, thresholds, sticky
// overflow/underflow flags, flush, and edge- or pulse-mode strobes.
// dato/empty are registered one edge after the state they describe.
module fifo_sync_p
    import fifo_pkg::*;
#(
    parameter int DW       = 8,
    parameter int AW       = 11,
    parameter int AF_LVL   = 2**AW - 4,
    parameter int AE_LVL   = 4,
    parameter bit STB_EDGE = 1'b1
) (
    input  logic          clk,
    input  logic          sys_rst,
    input  logic [DW-1:0] di,
    input  logic          we,
    input  logic          oe,
    input  logic          flush,
    input  logic          clr_flags,
    output logic [DW-1:0] dato,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          almost_full,
    output logic          almost_empty,
    output logic          ovf,
    output logic          udf
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(2**AW);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt;
    logic          empty_q, ovf_q, udf_q;
    logic          wr_evt, rd_evt, mem_we;
    logic          full_c, wr_ok, rd_ok, ovf_set, udf_set;
    fifo_stat_t    stat;

    assign full_c = (cnt == DEPTH_C);

    // A write while full is only taken if a read frees the slot this cycle;
    // flush discards both events and suppresses their flag side effects.
    assign wr_ok   = ~flush & wr_evt & (~full_c | rd_evt);
    assign rd_ok   = ~flush & rd_evt & (cnt != '0);
    assign ovf_set = ~flush & wr_evt & full_c & ~rd_evt;
    assign udf_set = ~flush & rd_evt & (cnt == '0);

    generate
        if (STB_EDGE == STB_EDGE_M) begin : g_edge
            logic [1:0] we_st, oe_st;

            // Strobe histories; reset and flush wipe them so no stale fall survives
            always_ff @(posedge clk) begin
                if (sys_rst || flush) begin
                    we_st <= '0;
                    oe_st <= '0;
                end else begin
                    we_st <= {we_st[0], we};
                    oe_st <= {oe_st[0], oe & ~empty_q};
                end
            end

            assign wr_evt = (we_st == STB_FALL);
            assign rd_evt = (oe_st == STB_FALL);
            // The tail cell tracks di while the strobe is held; when full the
            // tail aliases the head, so the cell is left alone then.
            assign mem_we = we & ~full_c & ~flush;
        end else begin : g_pulse
            assign wr_evt = we;
            assign rd_evt = oe;
            assign mem_we = wr_ok;
        end
    endgenerate

    fifo_mem #(.DW(DW), .AW(AW)) u_mem (
        .clk   (clk),
        .rst   (sys_rst),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (di),
        .raddr (rd_ptr),
        .rdata (dato)
    );

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (sys_rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky flags; a same-cycle set beats clr_flags, flush leaves them alone
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~clr_flags);
            udf_q <= udf_set | (udf_q & ~clr_flags);
        end
    end

    // empty is registered alongside the read data so both describe the same head
    always_ff @(posedge clk) begin
        if (sys_rst) empty_q <= 1'b1;
        else         empty_q <= (cnt == '0);
    end

    // Status bundle assembly
    always_comb begin
        stat              = '0;
        stat.empty        = empty_q;
        stat.full         = full_c;
        stat.almost_empty = (cnt <= AE_C);
        stat.almost_full  = (cnt >= AF_C);
        stat.ovf          = ovf_q;
        stat.udf          = udf_q;
    end

    assign empty        = stat.empty;
    assign full         = stat.full;
    assign almost_empty = stat.almost_empty;
    assign almost_full  = stat.almost_full;
    assign ovf          = stat.ovf;
    assign udf          = stat.udf;
    assign count        = cnt;

endmodule
